cache_miss_handler: RTL

- Back end of the cache access pipeline; consumes the registered stage-1 miss information (write flag, index, offset, tag, store data, one-hot replace way).
- Writes the dirty victim line back to memory, refills the line, merges a pending store, updates tag/valid/dirty, and returns the load word.
- Holds the pipeline stalled for the whole miss sequence.

---
 rtl/cache_miss_handler_pkg.sv | 21 ++
 rtl/cache_miss_handler_way_sel.sv | 16 +
 rtl/cache_miss_handler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_handler_pkg.sv
// Shared cache geometry and miss-handler FSM state encoding.
package cache_miss_handler_pkg;

   localparam int INDEX_WIDTH  = 6;
   localparam int OFFSET_WIDTH = 2;
   localparam int WORD_WIDTH   = 32;
   localparam int WAY_NUM      = 4;
   localparam int TAG_WIDTH    = 22;
   localparam int LINE_WORDS   = 2**OFFSET_WIDTH;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB_REQ  = 3'd1,
      WB_RD   = 3'd2,
      WB_WR   = 3'd3,
      RF_REQ  = 3'd4,
      RF_DATA = 3'd5,
      UPDATE  = 3'd6
   } state_e;

endpackage

// File: rtl/cache_miss_handler_way_sel.sv
// Lowest-set-bit cleaner: turns a possibly multi-hot way vector into one-hot.
module way_sel_enc
   import cache_miss_handler_pkg::*;
#(
   parameter int WAYS = WAY_NUM
) (
   input  logic [WAYS-1:0] way_i,
   output logic [WAYS-1:0] way_o
);

   // The two's-complement carry stops at the lowest set bit, isolating it.
   always_comb begin
      way_o = way_i & (~way_i + WAYS'(1));
   end

endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: dirty victim write-back, line refill with store merge,
// tag/valid/dirty update and critical-word load return; stalls while busy.
module cache_miss_handler
   import cache_miss_handler_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    miss_valid,
   input  logic                    miss_wr,
   input  logic [INDEX_WIDTH-1:0]  miss_index,
   input  logic [OFFSET_WIDTH-1:0] miss_offset,
   input  logic [TAG_WIDTH-1:0]    miss_tag,
   input  logic [WORD_WIDTH-1:0]   miss_store_data,
   input  logic [WAY_NUM-1:0]      miss_way,
   input  logic                    victim_dirty,
   input  logic [TAG_WIDTH-1:0]    victim_tag,
   output logic                    arr_rd_en,
   output logic [WAY_NUM-1:0]      arr_rd_way,
   output logic [INDEX_WIDTH-1:0]  arr_rd_index,
   output logic [OFFSET_WIDTH-1:0] arr_rd_word,
   input  logic [WORD_WIDTH-1:0]   arr_rd_data,
   output logic                    arr_wr_en,
   output logic [WAY_NUM-1:0]      arr_wr_way,
   output logic [INDEX_WIDTH-1:0]  arr_wr_index,
   output logic [OFFSET_WIDTH-1:0] arr_wr_word,
   output logic [WORD_WIDTH-1:0]   arr_wr_data,
   output logic                    tag_wr_en,
   output logic [TAG_WIDTH-1:0]    tag_wr_tag,
   output logic                    tag_wr_dirty,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic                    mem_req_wr,
   output logic [31:0]             mem_req_addr,
   output logic                    mem_wvalid,
   input  logic                    mem_wready,
   output logic [WORD_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_rvalid,
   input  logic [WORD_WIDTH-1:0]   mem_rdata,
   output logic                    load_valid,
   output logic [WORD_WIDTH-1:0]   load_data,
   output logic                    stall,
   output logic                    done
);

   localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(LINE_WORDS - 1);

   state_e                  state_q, state_d;
   logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
   logic                    wfirst_q, wfirst_d;
   logic                    load_valid_q, load_valid_d;
   logic [WORD_WIDTH-1:0]   load_data_q, load_data_d;

   logic                    wr_q, wr_d;
   logic [INDEX_WIDTH-1:0]  index_q, index_d;
   logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
   logic [TAG_WIDTH-1:0]    tag_q, tag_d;
   logic [WORD_WIDTH-1:0]   sdata_q, sdata_d;
   logic [WAY_NUM-1:0]      way_q, way_d;
   logic [TAG_WIDTH-1:0]    vtag_q, vtag_d;
   logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;

   logic [WAY_NUM-1:0]      way_clean;
   logic                    accept;
   logic                    crit;

   way_sel_enc #(.WAYS(WAY_NUM)) u_way_sel (
      .way_i (miss_way),
      .way_o (way_clean)
   );

   function automatic logic [31:0] line_addr(input logic [TAG_WIDTH-1:0]   t,
                                             input logic [INDEX_WIDTH-1:0] i);
      return {t, i, {OFFSET_WIDTH{1'b0}}, 2'b00};
   endfunction

   assign accept     = (state_q == IDLE) & miss_valid & (|miss_way);
   assign crit       = (beat_q == offset_q);
   assign stall      = (state_q != IDLE) | (miss_valid & (|miss_way));
   assign load_valid = load_valid_q;
   assign load_data  = load_data_q;

   // Control state: FSM, beat counter, write-beat capture flag, load return.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         wfirst_q     <= 1'b0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         wfirst_q     <= wfirst_d;
         load_valid_q <= load_valid_d;
         load_data_q  <= load_data_d;
      end
   end

   // Captured miss context and the held write-back beat; no reset needed.
   always_ff @(posedge clk) begin
      wr_q     <= wr_d;
      index_q  <= index_d;
      offset_q <= offset_d;
      tag_q    <= tag_d;
      sdata_q  <= sdata_d;
      way_q    <= way_d;
      vtag_q   <= vtag_d;
      wdata_q  <= wdata_d;
   end

   // Next-state and output decode for the miss sequence.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      wfirst_d      = 1'b0;
      load_valid_d  = 1'b0;
      load_data_d   = load_data_q;
      wr_d          = wr_q;
      index_d       = index_q;
      offset_d      = offset_q;
      tag_d         = tag_q;
      sdata_d       = sdata_q;
      way_d         = way_q;
      vtag_d        = vtag_q;
      wdata_d       = wdata_q;
      arr_rd_en     = 1'b0;
      arr_rd_way    = '0;
      arr_rd_index  = '0;
      arr_rd_word   = '0;
      arr_wr_en     = 1'b0;
      arr_wr_way    = '0;
      arr_wr_index  = '0;
      arr_wr_word   = '0;
      arr_wr_data   = '0;
      tag_wr_en     = 1'b0;
      tag_wr_tag    = '0;
      tag_wr_dirty  = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_wr    = 1'b0;
      mem_req_addr  = '0;
      mem_wvalid    = 1'b0;
      mem_wdata     = '0;
      done          = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               wr_d     = miss_wr;
               index_d  = miss_index;
               offset_d = miss_offset;
               tag_d    = miss_tag;
               sdata_d  = miss_store_data;
               way_d    = way_clean;
               vtag_d   = victim_tag;
               beat_d   = '0;
               state_d  = victim_dirty ? WB_REQ : RF_REQ;
            end
         end
         WB_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_wr    = 1'b1;
            mem_req_addr  = line_addr(vtag_q, index_q);
            if (mem_req_ready) begin
               beat_d  = '0;
               state_d = WB_RD;
            end
         end
         WB_RD: begin
            arr_rd_en    = 1'b1;
            arr_rd_way   = way_q;
            arr_rd_index = index_q;
            arr_rd_word  = beat_q;
            wfirst_d     = 1'b1;
            state_d      = WB_WR;
         end
         WB_WR: begin
            // Read data is only guaranteed in the first cycle; hold it after.
            mem_wvalid = 1'b1;
            mem_wdata  = wfirst_q ? arr_rd_data : wdata_q;
            wdata_d    = mem_wdata;
            if (mem_wready) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = RF_REQ;
               end else begin
                  beat_d  = beat_q + OFFSET_WIDTH'(1);
                  state_d = WB_RD;
               end
            end
         end
         RF_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_wr    = 1'b0;
            mem_req_addr  = line_addr(tag_q, index_q);
            if (mem_req_ready) begin
               beat_d  = '0;
               state_d = RF_DATA;
            end
         end
         RF_DATA: begin
            if (mem_rvalid) begin
               arr_wr_en    = 1'b1;
               arr_wr_way   = way_q;
               arr_wr_index = index_q;
               arr_wr_word  = beat_q;
               arr_wr_data  = (wr_q && crit) ? sdata_q : mem_rdata;
               if (!wr_q && crit) begin
                  load_data_d  = mem_rdata;
                  load_valid_d = 1'b1;
               end
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = UPDATE;
               end else begin
                  beat_d  = beat_q + OFFSET_WIDTH'(1);
               end
            end
         end
         UPDATE: begin
            tag_wr_en    = 1'b1;
            tag_wr_tag   = tag_q;
            tag_wr_dirty = wr_q;
            done         = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
